regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Operand-fetch and writeback sequencer for the multi-cycle MIPS datapath. It drives the register file's read and write ports. Per accepted instruction it:
- reads rs/rt from the register file;
- hands the operands to the ALU stage over a valid/ready handshake;
- takes the result back;
- writes it to the decoded destination register.

It processes one instruction at a time, so no forwarding is needed.

## Interface
Parameters:
- DATA_W, 32, datapath and register width
- ADDR_W, 5, register-index width (32 registers)

Ports:
- Clocking: one clock; reset is asynchronous and active-high. Ports are clk and reset.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word available
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  32  MIPS instruction word
- read1  out  ADDR_W  register-file read port 1 index (rs)
- read2  out  ADDR_W  register-file read port 2 index (rt)
- data1  in  DATA_W  register-file read data 1 (combinational from read1)
- data2  in  DATA_W  register-file read data 2 (combinational from read2)
- reg_write  out  ADDR_W  register-file write index
- wdata  out  DATA_W  register-file write data
- write  out  1  register-file write enable (write occurs on rising clk)
- op_valid  out  1  operands valid to ALU stage
- op_ready  in  1  ALU stage accepts operands
- op_a, op_b  out  DATA_W  captured rs / rt values
- op_imm  out  DATA_W  extended immediate instr[15:0]
- op_code, op_funct  out  6  instr[31:26], instr[5:0]
- res_valid  in  1  ALU result available
- res_data  in  DATA_W  ALU result
- res_ready  out  1  sequencer accepts result

## Operation
State machine:
- IDLE: instr_ready=1. On instr_valid, capture instr into instr_q, then go to READ.
- READ: capture data1→op_a and data2→op_b at the clock edge, then go to ISSUE.
- ISSUE: op_valid=1 and outputs held stable until op_ready. Then go to WAIT.
- WAIT: res_ready=1. On res_valid, capture res_data into res_q. If wb_en, go to WB; otherwise go to IDLE.
- WB: write=1, reg_write=dest, wdata=res_q for exactly one cycle, then go to IDLE.

Register indices: read1=instr_q[25:21] and read2=instr_q[20:16], held in every state.

Destination decode:
- opcode 0x00 → dest = rd (instr_q[15:11]).
- opcodes 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0F, 0x23 → dest = rt.
- All others (e.g. 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j) → no write.
- wb_en = writes_reg && dest≠0. Register 0 is never written.

Immediate extension:
- Zero-extend for 0x0C (andi) and 0x0D (ori).
- Sign-extend otherwise.

## Timing
- Reset values: state IDLE; instr_q, op_a, op_b, res_q all 0. Outputs: write=0, op_valid=0, res_ready=0, reg_write=0, wdata=0, read1=read2=0. instr_ready=1 once reset is low.
- Minimum latency with op_ready and res_valid already high:
  - accept at cycle 0, READ cycle 1, ISSUE cycle 2, WAIT cycle 3, WB cycle 4;
  - register updated at the end of cycle 4;
  - next accept in cycle 5.
- Back-to-back throughput is 5 cycles per writing instruction and 4 per non-writing instruction.
- ISSUE and WAIT stall indefinitely. Outputs stay stable while op_valid && !op_ready.
- res_valid asserted before WAIT is ignored; the ALU stage must hold it.
- Reset asserted mid-operation: immediate return to IDLE. No write pulse is produced and captured state is cleared.
- Read-after-write is safe: the WB write commits before the next instruction's READ edge.

## Structure
- Shared package regfile_seq_pkg holds:
  - state enum {IDLE, READ, ISSUE, WAIT, WB};
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J).
- One combinational sub-module, rf_dest_decode: instr → dest, wb_en, op_imm.

## Test plan
- Reset then R-type add (instr 0x01095020, rs=8, rt=9, rd=10), data1=5, data2=7, res_data=12 → op_a=5, op_b=7 in ISSUE; write=1, reg_write=10, wdata=12 in cycle 4.
- addi rt=3, imm=0xFFFF, res_data=0x2A → op_imm=0xFFFFFFFF; reg_write=3. ori imm=0xFFFF → op_imm=0x0000FFFF.
- sw (0x2B) and R-type with rd=0 → full handshake completes, write never asserted, return to IDLE after WAIT.
- op_ready low for 3 cycles, then res_valid delayed 4 cycles → op_valid and op_a/op_b stable throughout; single write pulse.
- reset asserted during WAIT → write stays 0, instr_ready=1 after release, next instruction sequenced normally.
- Two back-to-back instructions: first writes reg 4=0x99, second reads rs=4 → op_a=0x99 (with a modelled register file).

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types and MIPS opcode constants for the register-file sequencer.
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    ISSUE,
    WAIT,
    WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/rf_dest_decode.sv
// Combinational decode of writeback destination, write enable and immediate.
module rf_dest_decode
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] dest,
  output logic              wb_en,
  output logic [DATA_W-1:0] op_imm
);

  logic [5:0] opcode;
  logic       writes_reg;
  logic       zext;
  logic       unused_rs;

  // rs only feeds the read port, never the writeback path
  assign unused_rs = ^instr[25:21];

  // Destination select, register-0 suppression and immediate extension
  always_comb begin
    opcode     = instr[31:26];
    writes_reg = 1'b0;
    dest       = '0;
    case (opcode)
      OP_RTYPE: begin
        writes_reg = 1'b1;
        dest       = ADDR_W'(instr[15:11]);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        writes_reg = 1'b1;
        dest       = ADDR_W'(instr[20:16]);
      end
      default: writes_reg = 1'b0;
    endcase
    wb_en  = writes_reg && (dest != '0);
    zext   = (opcode == OP_ANDI) || (opcode == OP_ORI);
    op_imm = zext ? {{(DATA_W-16){1'b0}}, instr[15:0]}
                  : {{(DATA_W-16){instr[15]}}, instr[15:0]};
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Operand-fetch / writeback sequencer for the multi-cycle MIPS datapath.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] read1,
  output logic [ADDR_W-1:0] read2,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [ADDR_W-1:0] reg_write,
  output logic [DATA_W-1:0] wdata,
  output logic              write,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_imm,
  output logic [5:0]        op_code,
  output logic [5:0]        op_funct,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready
);

  state_t            state;
  state_t            state_nx;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] res_q;
  logic [ADDR_W-1:0] dest;
  logic              wb_en;

  rf_dest_decode #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dec (
    .instr (instr_q),
    .dest  (dest),
    .wb_en (wb_en),
    .op_imm(op_imm)
  );

  assign read1    = ADDR_W'(instr_q[25:21]);
  assign read2    = ADDR_W'(instr_q[20:16]);
  assign op_code  = instr_q[31:26];
  assign op_funct = instr_q[5:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Instruction, operand and result capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res_q   <= '0;
    end else begin
      if (state == IDLE && instr_valid) instr_q <= instr;
      if (state == READ) begin
        op_a <= data1;
        op_b <= data2;
      end
      if (state == WAIT && res_valid) res_q <= res_data;
    end
  end

  // Next-state and handshake / write-port outputs
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    op_valid    = 1'b0;
    res_ready   = 1'b0;
    write       = 1'b0;
    reg_write   = '0;
    wdata       = '0;
    case (state)
      IDLE: begin
        instr_ready = !reset;
        if (instr_valid) state_nx = READ;
      end
      READ: state_nx = ISSUE;
      ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) state_nx = WAIT;
      end
      WAIT: begin
        res_ready = 1'b1;
        if (res_valid) state_nx = wb_en ? WB : IDLE;
      end
      WB: begin
        write     = 1'b1;
        reg_write = dest;
        wdata     = res_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with a modelled register file.
module tb_regfile_sequencer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [5:0]  code;
    logic [5:0]  funct;
  } op_exp_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    int unsigned lat;
  } wr_exp_t;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  reg_write;
  logic [31:0] wdata;
  logic        write;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_imm;
  logic [5:0]  op_code;
  logic [5:0]  op_funct;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;

  logic [31:0] rf [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  op_exp_t     op_q[$];
  wr_exp_t     wr_q[$];
  logic        wb_q[$];
  int unsigned gap_q[$];

  int unsigned cyc;
  int unsigned last_acc;
  int          total;
  int          bad;
  logic        done;
  logic        was_reset;
  logic        res_done_prev;
  logic        stall_prev;
  logic [127:0] snap;

  regfile_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .read1      (read1),
    .read2      (read2),
    .data1      (data1),
    .data2      (data2),
    .reg_write  (reg_write),
    .wdata      (wdata),
    .write      (write),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_imm     (op_imm),
    .op_code    (op_code),
    .op_funct   (op_funct),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: preload port for setup, DUT write port otherwise
  assign data1 = rf[read1];
  assign data2 = rf[read2];
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (write && reg_write != 5'd0) rf[reg_write] <= wdata;
  end

  // Free-running cycle counter for latency / throughput measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: compares every DUT event against the scoreboard queues
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_write", 128'(write), 128'd0);
      chk("reset_handshake", 128'({op_valid, res_ready, instr_ready}), 128'd0);
      chk("reset_wport", 128'({reg_write, wdata}), 128'd0);
      chk("reset_rport", 128'({read1, read2}), 128'd0);
      stall_prev    = 1'b0;
      res_done_prev = 1'b0;
    end else begin
      if (was_reset) chk("ready_after_reset", 128'(instr_ready), 128'd1);
      if (instr_valid && instr_ready) begin
        if (gap_q.size() == 0) chk("accept_unexpected", 128'd1, 128'd0);
        else begin
          int unsigned g;
          g = gap_q.pop_front();
          if (g != 0) chk("accept_gap", 128'(cyc - last_acc), 128'(g));
        end
        last_acc = cyc;
      end
      if (stall_prev && op_valid)
        chk("issue_stable", {10'd0, op_a, op_b, op_imm, op_code, op_funct, read1, read2}, snap);
      if (op_valid && op_ready) begin
        if (op_q.size() == 0) chk("op_unexpected", 128'd1, 128'd0);
        else begin
          op_exp_t e;
          e = op_q.pop_front();
          chk("op_a", 128'(op_a), 128'(e.a));
          chk("op_b", 128'(op_b), 128'(e.b));
          chk("op_imm", 128'(op_imm), 128'(e.imm));
          chk("op_code_funct", 128'({op_code, op_funct}), 128'({e.code, e.funct}));
        end
      end
      if (res_done_prev) begin
        if (wb_q.size() == 0) chk("result_unexpected", 128'd1, 128'd0);
        else begin
          logic e;
          e = wb_q.pop_front();
          chk("wb_after_result", 128'({write, instr_ready}), 128'({e, !e}));
        end
      end
      if (write) begin
        if (wr_q.size() == 0) chk("write_unexpected", 128'({reg_write, wdata}), 128'd0);
        else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          chk("reg_write", 128'(reg_write), 128'(w.idx));
          chk("wdata", 128'(wdata), 128'(w.data));
          if (w.lat != 0) chk("wb_latency", 128'(cyc - last_acc), 128'(w.lat));
        end
      end
      res_done_prev = res_valid && res_ready;
      stall_prev    = op_valid && !op_ready;
      snap          = {10'd0, op_a, op_b, op_imm, op_code, op_funct, read1, read2};
    end
    was_reset = reset;
    if (done) begin
      chk("op_q_drained", 128'(op_q.size()), 128'd0);
      chk("wr_q_drained", 128'(wr_q.size()), 128'd0);
      chk("wb_q_drained", 128'(wb_q.size()), 128'd0);
      chk("gap_q_drained", 128'(gap_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic wait_for(input int unsigned which, input string nm);
    int unsigned n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit) begin
      @(negedge clk);
      case (which)
        0:       hit = instr_ready;
        1:       hit = op_valid;
        default: hit = res_ready;
      endcase
      if (!hit) begin
        n++;
        if (n > 200) begin
          $display("FAIL %s: got no response after %0d cycles, want one", nm, n);
          $fatal(1, "handshake timeout");
        end
      end
    end
  endtask

  task automatic run_instr(input logic [31:0] iw, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] eimm, input logic ewb, input logic [4:0] eidx,
                           input int unsigned elat, input int unsigned egap,
                           input int unsigned opd, input int unsigned resd, input logic [31:0] rv);
    op_q.push_back('{a: ea, b: eb, imm: eimm, code: iw[31:26], funct: iw[5:0]});
    gap_q.push_back(egap);
    wb_q.push_back(ewb);
    if (ewb) wr_q.push_back('{idx: eidx, data: rv, lat: elat});
    instr       = iw;
    instr_valid = 1'b1;
    op_ready    = (opd == 0);
    res_valid   = (resd == 0);
    res_data    = rv;
    wait_for(0, "accept");
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = '0;
    wait_for(1, "op_valid");
    if (opd != 0) begin
      repeat (opd) @(posedge clk);
      #1 op_ready = 1'b1;
    end
    @(posedge clk); #1;
    op_ready = 1'b0;
    wait_for(2, "res_ready");
    if (resd != 0) begin
      repeat (resd) @(posedge clk);
      #1 res_valid = 1'b1;
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  // Stimulus: directed instruction sequence
  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; op_ready = 1'b0;
    res_valid = 1'b0; res_data = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    cyc = 0; last_acc = 0; total = 0; bad = 0; done = 1'b0;
    was_reset = 1'b0; res_done_prev = 1'b0; stall_prev = 1'b0; snap = '0;

    for (int unsigned i = 0; i < 32; i++) begin
      pl_en   = 1'b1;
      pl_addr = 5'(i);
      case (i)
        8:       pl_data = 32'd5;
        9:       pl_data = 32'd7;
        5:       pl_data = 32'h55;
        default: pl_data = 32'd0;
      endcase
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // add $10,$8,$9 at minimum latency
    run_instr(32'h01095020, 32'd5, 32'd7, 32'h00005020, 1'b1, 5'd10, 4, 0, 0, 0, 32'd12);
    // addi $3,$8,-1 : sign-extended immediate
    run_instr(32'h2103FFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 5'd3, 4, 0, 0, 0, 32'h2A);
    // ori $5,$0,0xFFFF : zero-extended immediate
    run_instr(32'h3405FFFF, 32'd0, 32'h55, 32'h0000FFFF, 1'b1, 5'd5, 4, 0, 0, 0, 32'h1234);
    // andi $6,$8,0x8001 : zero-extended immediate
    run_instr(32'h31068001, 32'd5, 32'd0, 32'h00008001, 1'b1, 5'd6, 4, 0, 0, 0, 32'd1);
    // sw: no writeback
    run_instr(32'hAD090004, 32'd5, 32'd7, 32'h00000004, 1'b0, 5'd0, 0, 0, 0, 0, 32'hDEAD);
    // add $0,$8,$9: register 0 never written; non-writing throughput 4
    run_instr(32'h01090020, 32'd5, 32'd7, 32'h00000020, 1'b0, 5'd0, 0, 4, 0, 0, 32'hBEEF);
    // beq with negative offset
    run_instr(32'h11098000, 32'd5, 32'd7, 32'hFFFF8000, 1'b0, 5'd0, 0, 4, 0, 0, 32'd1);
    // add $11: op_ready stalled 3 cycles, result delayed 4 cycles
    run_instr(32'h01095820, 32'd5, 32'd7, 32'h00005820, 1'b1, 5'd11, 11, 4, 3, 4, 32'h77);

    // reset asserted while waiting for the result
    op_q.push_back('{a: 32'd5, b: 32'd7, imm: 32'h00005020, code: 6'h00, funct: 6'h20});
    gap_q.push_back(0);
    instr = 32'h01095020; instr_valid = 1'b1; op_ready = 1'b1; res_valid = 1'b0;
    wait_for(0, "accept_rst");
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = '0;
    wait_for(1, "op_valid_rst");
    @(posedge clk); #1;
    op_ready = 1'b0;
    wait_for(2, "res_ready_rst");
    @(posedge clk); #1;
    reset = 1'b1; res_valid = 1'b1; res_data = 32'hBAD;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; res_valid = 1'b0;

    // back-to-back read-after-write through the modelled register file
    run_instr(32'h20040000, 32'd0, 32'd0, 32'h00000000, 1'b1, 5'd4, 4, 0, 0, 0, 32'h99);
    run_instr(32'h00886020, 32'h99, 32'd5, 32'h00006020, 1'b1, 5'd12, 4, 5, 0, 0, 32'h9E);

    repeat (4) @(posedge clk);
    #1 done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
